line_prefetcher: RTL and testbench

LINE_PREFETCHER -- requirements
Module: line_prefetcher

---
 rtl/line_prefetcher.sv | 123 ++++++++++++
 tb/tb_line_prefetcher.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_prefetcher.sv
// line_prefetcher: double-buffered SRAM line fetcher with bounded outstanding reads.
// Define LINE_PREFETCH_STATS_EN to enable the StallCycles credit-stall counter.
module line_prefetcher #(
    parameter int LINE_WORDS      = 320,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          BOARD_CLK,
    input  logic                          RESET,
    input  logic                          LineStart,
    input  logic [19:0]                   LineBase,
    output logic                          QueueReadReq,
    output logic [19:0]                   AddressToSRAM,
    input  logic                          DataReady,
    input  logic [15:0]                   DataFromSRAM,
    input  logic [$clog2(LINE_WORDS)-1:0] PixAddr,
    output logic [15:0]                   PixData,
    output logic                          Busy,
    output logic                          LineDone,
    output logic                          Overrun,
    output logic [15:0]                   StallCycles
);
    localparam int CW = $clog2(LINE_WORDS + 1);
    localparam int MW = $clog2(2 * LINE_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [19:0]     base_q, base_d;
    logic [CW-1:0]   issued_q, issued_d, received_q, received_d;
    logic [3:0]      outst_q, outst_d;
    logic            fill_q, fill_d, ovr_q, ovr_d;
    logic [15:0]     pix_q, pix_d;
    logic [15:0]     mem [2*LINE_WORDS];
    logic            accept, issue, take;
    logic [MW-1:0]   waddr, raddr;

    assign accept = state_q == IDLE && LineStart;
    assign issue  = state_q == ISSUE && outst_q < 4'(MAX_OUTSTANDING);
    // Returns only count while a line is in flight; stray pulses elsewhere are dropped.
    assign take   = DataReady && (state_q == ISSUE || state_q == DRAIN) && received_q < CW'(LINE_WORDS);
    assign waddr  = MW'(received_q) + (fill_q ? MW'(LINE_WORDS) : MW'(0));
    assign raddr  = MW'(PixAddr) + (fill_q ? MW'(0) : MW'(LINE_WORDS));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        issued_d   = issue ? issued_q + CW'(1) : issued_q;
        received_d = take ? received_q + CW'(1) : received_q;
        outst_d    = outst_q + 4'(issue) - 4'(take);
        fill_d     = fill_q;
        ovr_d      = ovr_q || (LineStart && state_q != IDLE);
        pix_d      = 32'(PixAddr) < LINE_WORDS ? mem[raddr] : 16'h0;
        case (state_q)
            IDLE: if (accept) begin
                base_d     = LineBase;
                issued_d   = '0;
                received_d = '0;
                outst_d    = '0;
                state_d    = ISSUE;
            end
            ISSUE: state_d = issued_d == CW'(LINE_WORDS) ? DRAIN : ISSUE;
            DRAIN: state_d = received_q == CW'(LINE_WORDS) ? DONE : DRAIN;
            DONE: begin
                fill_d  = ~fill_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            base_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            fill_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            fill_q     <= fill_d;
            ovr_q      <= ovr_d;
            pix_q      <= pix_d;
        end
    end

    always_ff @(posedge BOARD_CLK) begin
        if (take) mem[waddr] <= DataFromSRAM;
    end

    assign QueueReadReq  = issue;
    assign AddressToSRAM = issue ? base_q + 20'(issued_q) : 20'h0;
    assign PixData       = pix_q;
    assign Busy          = state_q != IDLE;
    assign LineDone      = state_q == DONE;
    assign Overrun       = ovr_q;

`ifdef LINE_PREFETCH_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) stall_d = '0;
        else if (state_q == ISSUE && outst_q == 4'(MAX_OUTSTANDING) && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign StallCycles = stall_q;
`else
    assign StallCycles = 16'h0;
`endif
endmodule

// File: tb/tb_line_prefetcher.sv
// tb_line_prefetcher: directed stimulus with an SRAM responder and a per-cycle
// reference model of request/return/bank behaviour for line_prefetcher.
module tb_line_prefetcher;
    localparam int LW = 8;
    localparam int MO = 2;

    logic        clk = 0, rst = 1, line_start = 0;
    logic [19:0] line_base = '0;
    logic        req, data_ready, busy, done, ovr;
    logic [19:0] addr;
    logic [15:0] data_from_sram, pix, stall;
    logic [2:0]  pix_addr = '0;

    logic        resp_dr = 0, man_dr = 0;
    logic [15:0] resp_data = '0, man_data = '0;
    assign data_ready     = resp_dr | man_dr;
    assign data_from_sram = man_dr ? man_data : resp_data;

    line_prefetcher #(.LINE_WORDS(LW), .MAX_OUTSTANDING(MO)) dut (
        .BOARD_CLK(clk), .RESET(rst), .LineStart(line_start), .LineBase(line_base),
        .QueueReadReq(req), .AddressToSRAM(addr), .DataReady(data_ready),
        .DataFromSRAM(data_from_sram), .PixAddr(pix_addr), .PixData(pix),
        .Busy(busy), .LineDone(done), .Overrun(ovr), .StallCycles(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          dly = 3;
    logic [15:0] data_base = '0;
    logic        lit_en = 0, lit_addr_en = 0;
    int          lit_id = 0;
    logic [31:0] lit_val = '0;
    logic [19:0] lit_addrs [LW];

    int          n_cmp = 0, n_bad = 0;
    logic        m_busy = 0, m_ovr = 0, m_disp = 1, m_pix_known = 1;
    logic [19:0] m_base = '0;
    int          m_req = 0, m_ret = 0, m_done_at = -1;
    logic [15:0] m_stall = '0, m_pix_exp = '0;
    logic [15:0] mb [2][LW];
    bit          mk [2][LW];
    int          pend [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state advances once per cycle after the DUT outputs of that cycle are checked.
    always @(negedge clk) begin : cmp
        int          outs;
        logic        in_issue, exp_req, dr, acc;
        logic [15:0] dd;
        if (rst) begin
            chk("rst_req", 32'(req), 0);
            chk("rst_addr", 32'(addr), 0);
            chk("rst_pix", 32'(pix), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_overrun", 32'(ovr), 0);
            chk("rst_stall", 32'(stall), 0);
            m_busy = 0; m_ovr = 0; m_disp = 1; m_req = 0; m_ret = 0; m_done_at = -1;
            m_stall = '0; m_pix_exp = '0; m_pix_known = 1; resp_dr = 0;
            pend.delete();
        end else begin
            outs     = m_req - m_ret;
            in_issue = m_busy && m_req < LW;
            exp_req  = in_issue && outs < MO;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("line_done", 32'(done), 32'(cyc == m_done_at));
            chk("overrun", 32'(ovr), 32'(m_ovr));
            chk("req", 32'(req), 32'(exp_req));
            if (m_pix_known) chk("pix", 32'(pix), 32'(m_pix_exp));
`ifdef LINE_PREFETCH_STATS_EN
            chk("stall", 32'(stall), 32'(m_stall));
`else
            chk("stall", 32'(stall), 0);
`endif
            if (req) begin
                chk("addr", 32'(addr), 32'(20'(m_base + 20'(m_req))));
                if (lit_addr_en && m_req < LW) chk("lit_addr", 32'(addr), 32'(lit_addrs[m_req]));
                pend.push_back(cyc + dly);
                m_req++;
            end
            resp_dr = pend.size() > 0 && pend[0] == cyc;
            if (resp_dr) begin
                void'(pend.pop_front());
                resp_data = data_base + 16'(m_ret);
            end
            dr = resp_dr | man_dr;
            dd = man_dr ? man_data : resp_data;
            if (dr && m_busy && cyc != m_done_at && m_ret < LW) begin
                mb[!m_disp][m_ret] = dd;
                mk[!m_disp][m_ret] = 1;
                m_ret++;
                if (m_ret == LW) m_done_at = cyc + 2;
            end
            m_pix_known = 32'(pix_addr) >= LW || mk[m_disp][pix_addr];
            m_pix_exp   = 32'(pix_addr) >= LW ? 16'h0 : mb[m_disp][pix_addr];
            acc = line_start && !m_busy;
            if (line_start && m_busy) m_ovr = 1;
`ifdef LINE_PREFETCH_STATS_EN
            if (acc) m_stall = '0;
            else if (in_issue && outs == MO && m_stall != 16'hFFFF) m_stall++;
`endif
            if (cyc == m_done_at) begin
                m_disp = !m_disp;
                m_busy = 0;
            end
            if (acc) begin
                m_busy = 1; m_base = line_base; m_req = 0; m_ret = 0;
            end
            if (lit_en) begin
                case (lit_id)
                    0: chk("lit_pix", 32'(pix), lit_val);
                    1: chk("lit_overrun", 32'(ovr), lit_val);
`ifdef LINE_PREFETCH_STATS_EN
                    2: chk("lit_stall_nonzero", 32'(stall != 0), 1);
`else
                    2: chk("lit_stall_zero", 32'(stall), 0);
`endif
                    default: chk("lit_idle", 32'(busy), 0);
                endcase
            end
        end
    end

    task automatic lit(input int id, input logic [31:0] v);
        @(posedge clk); #1 lit_id = id; lit_val = v; lit_en = 1;
        @(posedge clk); #1 lit_en = 0;
    endtask

    task automatic pulse();
        @(posedge clk); #1 line_start = 1;
        @(posedge clk); #1 line_start = 0;
    endtask

    task automatic start(input logic [19:0] b, input logic [15:0] d);
        @(posedge clk); #1 line_base = b; data_base = d;
        pulse();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        lit(3, 0);
    endtask

    task automatic sweep();
        for (int a = 0; a < LW; a++) begin
            @(posedge clk); #1 pix_addr = 3'(a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        start(20'h00200, 16'h5000);
        wait_idle();
        sweep();
        // Old bank must stay visible while the next line fills the other one.
        @(posedge clk); #1 pix_addr = 3'd5;
        for (int i = 0; i < LW; i++) lit_addrs[i] = 20'h00100 + 20'(i);
        lit_addr_en = 1;
        start(20'h00100, 16'hA000);
        lit(0, 32'h5005);
        wait_idle();
        lit_addr_en = 0;
        lit(0, 32'hA005);
        @(posedge clk); #1 man_dr = 1; man_data = 16'hDEAD;
        @(posedge clk); #1 man_dr = 0;
        sweep();
        lit_addrs[0] = 20'hFFFFE;
        lit_addrs[1] = 20'hFFFFF;
        for (int i = 2; i < LW; i++) lit_addrs[i] = 20'(i - 2);
        lit_addr_en = 1;
        start(20'hFFFFE, 16'hB000);
        wait_idle();
        lit_addr_en = 0;
        sweep();
        start(20'h00300, 16'hC000);
        pulse();
        wait_idle();
        lit(1, 1);
        dly = 10;
        start(20'h00400, 16'hD000);
        begin
            int n = 0;
            for (int i = 0; i < 200 && n < 4; i++) begin
                @(negedge clk);
                if (req) n++;
            end
        end
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        lit(1, 0);
        start(20'h00500, 16'hE000);
        wait_idle();
        lit(2, 0);
        sweep();
        dly = 3;
        start(20'h00600, 16'hF000);
        for (int i = 0; i < 300 && cyc != m_done_at; i++) begin
            @(posedge clk); #1;
        end
        line_start = 1;
        @(posedge clk); #1 line_start = 0;
        wait_idle();
        lit(1, 1);
        sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
